design_slot_guard: RTL
======================

# design_slot_guard

Per-design slot guard that sits inside each student design wrapper, on the receiving end of the active-low chip select and per-design reset driven by the top-level design multiplexer. It filters chip-select activation and holds the design core in reset for a fixed bring-up interval. Only after that does it hand the core the GPIO pads. On deselection it drains the pads to a safe state so two designs never drive the shared pins at once. All GPIO outputs are registered so pad-enable changes are glitch-free.

## Interface
Parameters:
- SEL_FILTER, 4: consecutive sampled-low `ncs` cycles required to accept a select (≥1).
- RST_HOLD, 8: cycles the core is held in reset after a select is accepted (≥1).
- DRAIN_CYCLES, 2: cycles the pads stay enabled driving 0 after deselect (≥1).
- OUT_MASK, 34'h3_FFFF_FFFF: pins the design may ever drive; a 0 bit forces that pin to input.

Ports:
- clk  input  1  system clock; the only clock.
- n_rst  input  1  synchronous, active-low reset.
- ncs  input  1  active-low chip select from the top-level design multiplexer.
- gpio_in  input  34  pad inputs.
- core_gpio_out  input  34  design core output values.
- core_gpio_oeb  input  34  design core output-enable-bar (1 = input).
- core_gpio_in  output  34  gated pad inputs to the core.
- core_n_rst  output  1  active-low reset to the core.
- core_en  output  1  core clock-enable; 0 freezes core state.
- gpio_out  output  34  registered pad outputs.
- gpio_oeb  output  34  registered pad enables-bar.
- active  output  1  high while in ACTIVE.

## Operation
- States: IDLE, SETTLE, HOLD, ACTIVE, DRAIN. A single counter is sized $clog2(max(SEL_FILTER, RST_HOLD, DRAIN_CYCLES)+1) and is cleared on every state entry.
- IDLE:
  - Outputs: core_n_rst=0, core_en=0, gpio_oeb=all 1s, gpio_out=0, core_gpio_in=0.
  - Exit when `ncs`=0 is sampled. If SEL_FILTER=1, go to HOLD; otherwise go to SETTLE with the counter at 1.
- SETTLE:
  - Outputs are the same as IDLE.
  - `ncs`=1 sampled: return to IDLE.
  - `ncs`=0 sampled: increment the counter. When the count reaches SEL_FILTER, go to HOLD.
- HOLD:
  - Outputs are the same as IDLE; the core stays in reset.
  - After RST_HOLD cycles, go to ACTIVE.
  - `ncs`=1 sampled: go directly to IDLE. The pads were never enabled, so no drain is needed.
- ACTIVE:
  - core_n_rst=1, core_en=1, active=1, core_gpio_in=gpio_in (combinational).
  - Registered pad outputs: gpio_out ← core_gpio_out & OUT_MASK; gpio_oeb ← core_gpio_oeb | ~OUT_MASK.
  - `ncs`=1 sampled: go to DRAIN.
- DRAIN:
  - core_en=0, core_n_rst=1, core_gpio_in=0.
  - gpio_out ← 0; gpio_oeb holds its last ACTIVE value.
  - After DRAIN_CYCLES cycles, go to IDLE.
  - `ncs` is ignored during DRAIN. A reselect is recognised only after returning to IDLE.
- core_n_rst, core_en and active are decodes of the state register. gpio_out and gpio_oeb are loaded each edge from the current state.
- Masked pins (OUT_MASK bit 0) read gpio_oeb=1 and gpio_out=0 in every state.

## Timing
- Reset: when n_rst=0 is sampled, the next state is IDLE and the counter is 0.
  - Resulting outputs: gpio_out=0, gpio_oeb=34'h3_FFFF_FFFF, core_n_rst=0, core_en=0, active=0.
  - Reset overrides all states, including mid-DRAIN; pads tri-state at that edge.
- Select latency: suppose `ncs` is first sampled low at edge E0 and stays low.
  - HOLD is entered at E(SEL_FILTER−1).
  - ACTIVE and core_n_rst=1 begin at E(SEL_FILTER+RST_HOLD−1).
  - The first core-driven pad value appears one edge later.
- Pass-through latency in ACTIVE: 1 cycle from core_gpio_out/oeb to gpio_out/oeb. core_gpio_in has 0 cycles of latency.
- Deselect: `ncs` sampled high at edge D in ACTIVE.
  - gpio_out=0 from edge D+1.
  - gpio_oeb returns to all 1s at edge D+DRAIN_CYCLES+1.
- A single-cycle `ncs` low glitch shorter than SEL_FILTER samples never releases core reset.

## Test plan
- Reset with `ncs`=0 held: all outputs at reset values during reset. After release, core_n_rst rises exactly SEL_FILTER+RST_HOLD edges later (12 with defaults).
- Glitch filter: `ncs` low for 3 cycles then high → state returns to IDLE, core_n_rst stays 0, gpio_oeb stays 34'h3_FFFF_FFFF.
- Pass-through with OUT_MASK=34'h3_FFFF_FF00: in ACTIVE, core_gpio_out=34'h2_AAAA_AAAA and core_gpio_oeb=0 → one cycle later gpio_out=34'h2_AAAA_AA00 and gpio_oeb=34'h0_0000_00FF.
- Deselect drain: `ncs` rises in ACTIVE → gpio_out=0 for 2 cycles with the pads still driven, then gpio_oeb=all 1s. core_en=0 throughout.
- Reselect during DRAIN: `ncs` falls 1 cycle into DRAIN → drain completes and IDLE is entered. A new SETTLE/HOLD sequence follows and ACTIVE is re-entered 12 edges after IDLE.
- Reset mid-HOLD and mid-ACTIVE: n_rst=0 for one cycle → IDLE at the next edge, pads tri-stated, core_n_rst=0.

Source files
------------

// File: rtl/design_slot_guard.sv
// Per-design slot guard: filters the active-low chip select, holds the core in reset
// during bring-up, then hands over the GPIO pads and drains them safely on deselect.
module design_slot_guard #(
    parameter int          SEL_FILTER   = 4,
    parameter int          RST_HOLD     = 8,
    parameter int          DRAIN_CYCLES = 2,
    parameter logic [33:0] OUT_MASK     = 34'h3_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        ncs,
    input  logic [33:0] gpio_in,
    input  logic [33:0] core_gpio_out,
    input  logic [33:0] core_gpio_oeb,
    output logic [33:0] core_gpio_in,
    output logic        core_n_rst,
    output logic        core_en,
    output logic [33:0] gpio_out,
    output logic [33:0] gpio_oeb,
    output logic        active
);

    localparam int MAX_AB  = (SEL_FILTER > RST_HOLD) ? SEL_FILTER : RST_HOLD;
    localparam int MAX_CNT = (MAX_AB > DRAIN_CYCLES) ? MAX_AB : DRAIN_CYCLES;
    localparam int CW      = $clog2(MAX_CNT + 1);

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t SF_LAST = cnt_t'(SEL_FILTER - 1);
    localparam cnt_t RH_LAST = cnt_t'(RST_HOLD - 1);
    localparam cnt_t DC_LAST = cnt_t'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        HOLD,
        ACTIVE,
        DRAIN
    } state_t;

    state_t state;
    state_t next_state;
    cnt_t   cnt;
    cnt_t   next_cnt;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // The counter restarts on every state change; SETTLE starts at 1 because the
    // sample that left IDLE already counts towards the filter.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        case (state)
            IDLE: begin
                if (!ncs) begin
                    if (SEL_FILTER == 1) begin
                        next_state = HOLD;
                        next_cnt   = '0;
                    end else begin
                        next_state = SETTLE;
                        next_cnt   = cnt_t'(1);
                    end
                end
            end
            SETTLE: begin
                if (ncs) begin
                    next_state = IDLE;
                    next_cnt   = '0;
                end else if (cnt == SF_LAST) begin
                    next_state = HOLD;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt + cnt_t'(1);
                end
            end
            HOLD: begin
                if (ncs) begin
                    next_state = IDLE;
                    next_cnt   = '0;
                end else if (cnt == RH_LAST) begin
                    next_state = ACTIVE;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt + cnt_t'(1);
                end
            end
            ACTIVE: begin
                if (ncs) begin
                    next_state = DRAIN;
                    next_cnt   = '0;
                end
            end
            DRAIN: begin
                if (cnt == DC_LAST) begin
                    next_state = IDLE;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt + cnt_t'(1);
                end
            end
            default: begin
                next_state = IDLE;
                next_cnt   = '0;
            end
        endcase
    end

    // Pads are loaded from the current state so every enable change comes off a flop;
    // during DRAIN the enables keep their last ACTIVE value while the data is forced low.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            gpio_out <= '0;
            gpio_oeb <= '1;
        end else begin
            case (state)
                ACTIVE: begin
                    gpio_out <= core_gpio_out & OUT_MASK;
                    gpio_oeb <= core_gpio_oeb | ~OUT_MASK;
                end
                DRAIN: begin
                    gpio_out <= '0;
                end
                default: begin
                    gpio_out <= '0;
                    gpio_oeb <= '1;
                end
            endcase
        end
    end

    assign core_n_rst   = (state == ACTIVE) || (state == DRAIN);
    assign core_en      = (state == ACTIVE);
    assign active       = (state == ACTIVE);
    assign core_gpio_in = (state == ACTIVE) ? gpio_in : '0;

endmodule
